// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with an explicit leading
// significand bit. One shared advance enable stalls all stages at once.
module fp_add_pipe #(
  parameter int EXP_W = 9,
  parameter int SIG_W = 30,
  localparam int W = 1 + EXP_W + SIG_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_op,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_sum,
  output logic         out_ovf,
  output logic         out_unf,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int STAGES = 3;
  localparam int LZW    = $clog2(SIG_W + 1);

  typedef struct packed {
    logic             sa;
    logic             sb;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] siga;
    logic [SIG_W-1:0] sigb;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W:0]   sum;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            en, acc;
  s1_t             s1_n, s1_q;
  s2_t             s2_n, s2_q;

  assign out_valid = vld_pipe[STAGES];
  assign en        = !out_valid | out_ready;
  assign in_ready  = en & !reset;
  assign acc       = in_valid & in_ready;

  function automatic logic [LZW-1:0] lzc(input logic [SIG_W-1:0] v);
    lzc = LZW'(SIG_W);
    for (int i = 0; i < SIG_W; i++)
      if (v[i]) lzc = LZW'(SIG_W - 1 - i);
  endfunction

  // S1: effective sign of b, magnitude swap, alignment of the smaller operand
  logic             sb_eff, swap;
  logic [W-2:0]     hi, lo;
  logic [EXP_W-1:0] d;

  always_comb begin
    sb_eff    = in_b[W-1] ^ in_op;
    swap      = in_b[W-2:0] > in_a[W-2:0];
    hi        = swap ? in_b[W-2:0] : in_a[W-2:0];
    lo        = swap ? in_a[W-2:0] : in_b[W-2:0];
    d         = hi[W-2:SIG_W] - lo[W-2:SIG_W];
    s1_n.sa   = swap ? sb_eff : in_a[W-1];
    s1_n.sb   = swap ? in_a[W-1] : sb_eff;
    s1_n.exp  = hi[W-2:SIG_W];
    s1_n.siga = hi[SIG_W-1:0];
    s1_n.sigb = (32'(d) >= 32'(SIG_W)) ? '0 : lo[SIG_W-1:0] >> d;
  end

  // S2: A is never smaller than B, so the difference cannot go negative
  always_comb begin
    s2_n.sign = s1_q.sa;
    s2_n.exp  = s1_q.exp;
    if (s1_q.sa == s1_q.sb) s2_n.sum = {1'b0, s1_q.siga} + {1'b0, s1_q.sigb};
    else                    s2_n.sum = {1'b0, s1_q.siga - s1_q.sigb};
  end

  // S3: normalize, saturate on exponent overflow, flush to +0 on underflow
  logic             n_sign, n_ovf, n_unf;
  logic [EXP_W-1:0] n_exp;
  logic [SIG_W-1:0] n_sig;
  logic [LZW-1:0]   lz;

  always_comb begin
    lz     = lzc(s2_q.sum[SIG_W-1:0]);
    n_sign = s2_q.sign;
    n_exp  = s2_q.exp;
    n_sig  = s2_q.sum[SIG_W-1:0];
    n_ovf  = 1'b0;
    n_unf  = 1'b0;
    if (s2_q.sum[SIG_W]) begin
      if (&s2_q.exp) begin
        n_exp = '1;
        n_sig = '1;
        n_ovf = 1'b1;
      end else begin
        n_exp = s2_q.exp + 1'b1;
        n_sig = s2_q.sum[SIG_W:1];
      end
    end else if (s2_q.sum == '0) begin
      n_sign = 1'b0;
      n_exp  = '0;
      n_sig  = '0;
    end else if (32'(s2_q.exp) < 32'(lz)) begin
      n_sign = 1'b0;
      n_exp  = '0;
      n_sig  = '0;
      n_unf  = 1'b1;
    end else begin
      n_exp = s2_q.exp - EXP_W'(lz);
      n_sig = s2_q.sum[SIG_W-1:0] << lz;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      out_sum  <= '0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      s1_q     <= s1_n;
      s2_q     <= s2_n;
      out_sum  <= {n_sign, n_exp, n_sig};
      out_ovf  <= vld_pipe[STAGES-1] & n_ovf;
      out_unf  <= vld_pipe[STAGES-1] & n_unf;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed vector bench for fp_add_pipe: value table, stall/backpressure order
// and stability, and reset with transactions in flight.
module tb_fp_add_pipe;
  localparam int EXP_W = 9;
  localparam int SIG_W = 30;
  localparam int W     = 1 + EXP_W + SIG_W;
  localparam int NV    = 12;

  logic         clk, reset, in_op, in_valid, in_ready;
  logic         out_ovf, out_unf, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out_sum;

  fp_add_pipe #(.EXP_W(EXP_W), .SIG_W(SIG_W)) dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_valid(in_valid), .in_ready(in_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] sum;
    logic         ovf;
    logic         unf;
  } vec_t;

  vec_t vt[NV];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [W-1:0] mk(input logic s, input int e, input logic [SIG_W-1:0] m);
    return {s, EXP_W'(e), m};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_one(input vec_t v, output logic [W-1:0] s, output logic ov,
                         output logic un, output int lat);
    @(negedge clk);
    in_a = v.a; in_b = v.b; in_op = v.op; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s = out_sum; ov = out_ovf; un = out_unf;
  endtask

  initial begin
    logic [W-1:0]   s;
    logic           ov, un, took;
    logic [W+1:0]   hold;
    logic           have_hold;
    int             lat, idx, got, acc_early, seen;

    // expected values worked out by hand from {sign,exp,sig}
    vt[0]  = '{mk(0,100,30'h20000000), mk(0,100,30'h20000000), 0, mk(0,101,30'h20000000), 0, 0};
    vt[1]  = '{mk(0,100,30'h20000000), mk(0,100,30'h20000000), 1, mk(0,0,30'h0), 0, 0};
    vt[2]  = '{mk(0,100,30'h20000000), mk(0,60,30'h3FFFFFFF), 0, mk(0,100,30'h20000000), 0, 0};
    vt[3]  = '{mk(0,2,30'h30000000), mk(0,2,30'h2FFFFFFF), 1, mk(0,0,30'h0), 0, 1};
    vt[4]  = '{mk(0,511,30'h30000000), mk(0,511,30'h30000000), 0, mk(0,511,30'h3FFFFFFF), 1, 0};
    vt[5]  = '{mk(1,50,30'h20000000), mk(0,50,30'h30000000), 0, mk(0,49,30'h20000000), 0, 0};
    vt[6]  = '{mk(0,10,30'h20000000), mk(0,11,30'h20000000), 1, mk(1,10,30'h20000000), 0, 0};
    vt[7]  = '{mk(0,20,30'h20000000), mk(0,18,30'h3FFFFFFF), 0, mk(0,20,30'h2FFFFFFF), 0, 0};
    vt[8]  = '{mk(0,0,30'h0), mk(1,7,30'h25555555), 0, mk(1,7,30'h25555555), 0, 0};
    vt[9]  = '{mk(0,40,30'h20000000), mk(0,11,30'h3FFFFFFF), 0, mk(0,40,30'h20000001), 0, 0};
    vt[10] = '{mk(0,29,30'h20000000), mk(0,28,30'h3FFFFFFF), 1, mk(0,0,30'h20000000), 0, 0};
    vt[11] = '{mk(0,510,30'h30000000), mk(0,510,30'h30000000), 0, mk(0,511,30'h30000000), 0, 0};

    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_op = 1'b0;
    in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", {out_sum, out_ovf, out_unf}, 0);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < NV; i++) begin
      run_one(vt[i], s, ov, un, lat);
      chk($sformatf("vec%0d_lat", i), lat, 3);
      chk($sformatf("vec%0d_sum", i), s, vt[i].sum);
      chk($sformatf("vec%0d_flags", i), {ov, un}, {vt[i].ovf, vt[i].unf});
    end

    // six back-to-back offers against a sink that stalls for five cycles
    @(negedge clk);
    idx = 0; got = 0; acc_early = 0; have_hold = 1'b0; hold = '0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (idx < 6) begin
        in_a = vt[idx].a; in_b = vt[idx].b; in_op = vt[idx].op; in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        if (!out_ready) begin
          if (have_hold) chk("stall_hold", {out_sum, out_ovf, out_unf}, hold);
          else begin
            hold = {out_sum, out_ovf, out_unf};
            have_hold = 1'b1;
          end
        end else begin
          chk($sformatf("order%0d", got), {out_sum, out_ovf, out_unf},
              {vt[got].sum, vt[got].ovf, vt[got].unf});
          got++;
          have_hold = 1'b0;
        end
      end
      took = in_valid & in_ready;
      @(posedge clk);
      if (took) begin
        idx++;
        if (c < 5) acc_early++;
      end
    end
    in_valid = 1'b0;
    chk("stall_accepts", acc_early, 3);
    chk("stall_delivered", got, 6);

    // fill the pipe with three transactions, then reset before any leaves
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_a = vt[k+6].a; in_b = vt[k+6].b; in_op = vt[k+6].op; in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1 chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out", {out_sum, out_ovf, out_unf}, 0);
    reset = 1'b0; out_ready = 1'b1;
    #1 chk("mid_rst_release_ready", in_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flushed_none_emitted", seen, 0);
    run_one(vt[5], s, ov, un, lat);
    chk("after_rst_lat", lat, 3);
    chk("after_rst_sum", s, vt[5].sum);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
